muldiv_sequencer: RTL and testbench

Multi-cycle controller for the HI/LO multiply/divide resource. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and sequences an iterative radix-2 divider and a fixed-latency multiplier. It owns the HI/LO registers and stalls the pipeline when MFHI/MFLO, or a new muldiv op, arrives while an operation is in flight. It replaces the single-cycle HI/LO path beside the ALU.

---
 rtl/muldiv_sequencer_pkg.sv | 56 +++++
 rtl/muldiv_sequencer_if.sv | 27 ++
 rtl/muldiv_sequencer_div_core.sv | 56 +++++
 rtl/muldiv_sequencer.sv | 173 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer: op codes, FSM states
// and the instruction decode helper that lets the decoder drive start_i/op_i.
package muldiv_sequencer_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MUL_WAIT = 2'd1,
      ST_DIV_ITER = 2'd2,
      ST_DIV_FIX  = 2'd3
   } muldiv_state_t;

   typedef logic [5:0] opcode_t;
   typedef logic [5:0] func_t;

   localparam opcode_t OPC_SPECIAL = 6'h00;
   localparam func_t   FN_MTHI     = 6'h11;
   localparam func_t   FN_MTLO     = 6'h13;
   localparam func_t   FN_MULT     = 6'h18;
   localparam func_t   FN_MULTU    = 6'h19;
   localparam func_t   FN_DIV      = 6'h1A;
   localparam func_t   FN_DIVU     = 6'h1B;

   typedef struct packed {
      logic       valid;
      muldiv_op_t op;
   } muldiv_dec_t;

   // Maps a SPECIAL-class instruction onto a muldiv op; valid=0 for anything else.
   function automatic muldiv_dec_t muldiv_decode(input opcode_t opcode, input func_t func);
      muldiv_dec_t d;
      d.valid = 1'b0;
      d.op    = MD_MULT;
      if (opcode == OPC_SPECIAL) begin
         case (func)
            FN_MTHI:  begin d.valid = 1'b1; d.op = MD_MTHI;  end
            FN_MTLO:  begin d.valid = 1'b1; d.op = MD_MTLO;  end
            FN_MULT:  begin d.valid = 1'b1; d.op = MD_MULT;  end
            FN_MULTU: begin d.valid = 1'b1; d.op = MD_MULTU; end
            FN_DIV:   begin d.valid = 1'b1; d.op = MD_DIV;   end
            FN_DIVU:  begin d.valid = 1'b1; d.op = MD_DIVU;  end
            default:  ;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage <-> muldiv sequencer handshake bundle.
interface muldiv_sequencer_if;
   import muldiv_sequencer_pkg::*;

   logic        start_i;
   muldiv_op_t  op_i;
   logic [31:0] rs_i;
   logic [31:0] rt_i;
   logic        flush_i;
   logic        mf_req_i;
   logic        ready_o;
   logic        busy_o;
   logic        stall_o;
   logic        done_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   modport master (
      output start_i, op_i, rs_i, rt_i, flush_i, mf_req_i,
      input  ready_o, busy_o, stall_o, done_o, hi_o, lo_o
   );

   modport slave (
      input  start_i, op_i, rs_i, rt_i, flush_i, mf_req_i,
      output ready_o, busy_o, stall_o, done_o, hi_o, lo_o
   );
endinterface

// File: rtl/muldiv_sequencer_div_core.sv
// Unsigned radix-2 restoring divider, one quotient bit per step.
// The remainder never exceeds the divisor, so 32 bits of remainder plus a
// 33-bit shifted trial value cover the full unsigned range.
module muldiv_sequencer_div_core #(
   parameter int DIV_STEPS = 32
) (
   input  logic        clk,
   input  logic        reset_ni,
   input  logic        load_i,
   input  logic        step_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   output logic [31:0] quotient_o,
   output logic [31:0] remainder_o,
   output logic        last_step_o
);

   logic [31:0] quo_q;
   logic [31:0] rem_q;
   logic [31:0] dvs_q;
   logic [5:0]  cnt_q;
   logic [32:0] shifted;
   logic        ge;
   logic [31:0] sub;

   // Trial subtraction for the current step.
   always_comb begin
      shifted = {rem_q, quo_q[31]};
      ge      = (shifted >= {1'b0, dvs_q});
      sub     = shifted[31:0] - dvs_q;
   end

   // Operand load, then one shift/subtract per step.
   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else if (load_i) begin
         quo_q <= dividend_i;
         rem_q <= '0;
         dvs_q <= divisor_i;
         cnt_q <= '0;
      end else if (step_i) begin
         rem_q <= ge ? sub : shifted[31:0];
         quo_q <= {quo_q[30:0], ge};
         cnt_q <= cnt_q + 6'd1;
      end
   end

   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;
   assign last_step_o = (cnt_q == 6'(DIV_STEPS - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner: sequences the fixed-latency multiplier and iterative divider,
// stalls MFHI/MFLO and new ops while busy.
//
// state       | meaning
// ST_IDLE     | ready; MTHI/MTLO and divide-by-zero complete here
// ST_MUL_WAIT | product registered, counting down to HI/LO writeback
// ST_DIV_ITER | one restoring divider step per edge (32 edges)
// ST_DIV_FIX  | apply signs, write HI/LO, pulse done
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int MULT_LATENCY = 4,
   parameter int DIV_STEPS    = 32
) (
   input logic               clk,
   input logic               reset_ni,
   muldiv_sequencer_if.slave bus
);

   muldiv_state_t state_q, state_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;
   logic [63:0]   prod_q, prod_d;
   logic [3:0]    mcnt_q, mcnt_d;
   logic          done_q, done_d;
   logic          q_neg_q, q_neg_d, r_neg_q, r_neg_d;
   logic          busy;
   logic          accept;
   logic          div_load, div_step, div_last;
   logic          op_signed;
   logic [31:0]   rs_mag, rt_mag;
   logic [31:0]   quo, rem;
   logic [63:0]   ext_a, ext_b;

   assign accept    = bus.start_i && !bus.flush_i && (state_q == ST_IDLE);
   assign op_signed = (bus.op_i == MD_MULT) || (bus.op_i == MD_DIV);
   assign ext_a     = {{32{op_signed & bus.rs_i[31]}}, bus.rs_i};
   assign ext_b     = {{32{op_signed & bus.rt_i[31]}}, bus.rt_i};
   assign rs_mag    = (op_signed && bus.rs_i[31]) ? (~bus.rs_i + 32'd1) : bus.rs_i;
   assign rt_mag    = (op_signed && bus.rt_i[31]) ? (~bus.rt_i + 32'd1) : bus.rt_i;

   muldiv_sequencer_div_core #(.DIV_STEPS(DIV_STEPS)) u_div (
      .clk         (clk),
      .reset_ni    (reset_ni),
      .load_i      (div_load),
      .step_i      (div_step),
      .dividend_i  (rs_mag),
      .divisor_i   (rt_mag),
      .quotient_o  (quo),
      .remainder_o (rem),
      .last_step_o (div_last)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) state_q <= ST_IDLE;
      else           state_q <= state_d;
   end

   // Next-state logic; flush always returns to idle.
   always_comb begin
      state_d = state_q;
      if (bus.flush_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  case (bus.op_i)
                     MD_MULT, MD_MULTU: state_d = ST_MUL_WAIT;
                     MD_DIV, MD_DIVU:   if (bus.rt_i != '0) state_d = ST_DIV_ITER;
                     default:           ;
                  endcase
               end
            end
            ST_MUL_WAIT: if (mcnt_q == '0) state_d = ST_IDLE;
            ST_DIV_ITER: if (div_last) state_d = ST_DIV_FIX;
            ST_DIV_FIX:  state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
         endcase
      end
   end

   // Datapath next values: HI/LO commits, product, countdown, divider control.
   always_comb begin
      hi_d     = hi_q;
      lo_d     = lo_q;
      prod_d   = prod_q;
      mcnt_d   = mcnt_q;
      done_d   = 1'b0;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      div_load = 1'b0;
      div_step = 1'b0;
      if (!bus.flush_i) begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  case (bus.op_i)
                     MD_MTHI: hi_d = bus.rs_i;
                     MD_MTLO: lo_d = bus.rs_i;
                     MD_MULT, MD_MULTU: begin
                        prod_d = ext_a * ext_b;
                        mcnt_d = 4'(MULT_LATENCY - 1);
                     end
                     MD_DIV, MD_DIVU: begin
                        if (bus.rt_i == '0) begin
                           hi_d   = '0;
                           lo_d   = '0;
                           done_d = 1'b1;
                        end else begin
                           div_load = 1'b1;
                           q_neg_d  = op_signed & (bus.rs_i[31] ^ bus.rt_i[31]);
                           r_neg_d  = op_signed & bus.rs_i[31];
                        end
                     end
                     default: ;
                  endcase
               end
            end
            ST_MUL_WAIT: begin
               if (mcnt_q == '0) begin
                  hi_d   = prod_q[63:32];
                  lo_d   = prod_q[31:0];
                  done_d = 1'b1;
               end else begin
                  mcnt_d = mcnt_q - 4'd1;
               end
            end
            ST_DIV_ITER: div_step = 1'b1;
            ST_DIV_FIX: begin
               lo_d   = q_neg_q ? (~quo + 32'd1) : quo;
               hi_d   = r_neg_q ? (~rem + 32'd1) : rem;
               done_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         hi_q    <= '0;
         lo_q    <= '0;
         prod_q  <= '0;
         mcnt_q  <= '0;
         done_q  <= 1'b0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
      end else begin
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         prod_q  <= prod_d;
         mcnt_q  <= mcnt_d;
         done_q  <= done_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
      end
   end

   // Handshake outputs derived from state.
   always_comb begin
      busy        = (state_q != ST_IDLE);
      bus.busy_o  = busy;
      bus.ready_o = !busy;
      bus.stall_o = (bus.mf_req_i || bus.start_i) && busy;
   end

   assign bus.done_o = done_q;
   assign bus.hi_o   = hi_q;
   assign bus.lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
   import muldiv_sequencer_pkg::*;

   logic clk = 1'b0;
   logic reset_ni;
   int   checks = 0;
   int   errors = 0;
   int   n;
   int   stall_cnt;
   int   done_seen;
   muldiv_dec_t dec;

   muldiv_sequencer_if bus();

   muldiv_sequencer #(.MULT_LATENCY(4), .DIV_STEPS(32)) dut (
      .clk      (clk),
      .reset_ni (reset_ni),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
      bus.start_i = 1'b1;
      bus.op_i    = op;
      bus.rs_i    = a;
      bus.rt_i    = b;
      tick();
      bus.start_i = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (bus.done_o !== 1'b1 && cyc < 100) begin
         tick();
         cyc++;
      end
   endtask

   initial begin
      reset_ni     = 1'b0;
      bus.start_i  = 1'b0;
      bus.op_i     = MD_MULT;
      bus.rs_i     = '0;
      bus.rt_i     = '0;
      bus.flush_i  = 1'b0;
      bus.mf_req_i = 1'b0;
      repeat (2) @(negedge clk);

      chk32("rst_hi", bus.hi_o, 32'h0);
      chk32("rst_lo", bus.lo_o, 32'h0);
      chk1("rst_busy", bus.busy_o, 1'b0);
      chk1("rst_ready", bus.ready_o, 1'b1);
      chk1("rst_done", bus.done_o, 1'b0);
      reset_ni = 1'b1;
      tick();

      dec = muldiv_decode(6'h00, 6'h1A);
      chk1("dec_div_valid", dec.valid, 1'b1);
      chk32("dec_div_op", 32'(dec.op), 32'(MD_DIV));
      dec = muldiv_decode(6'h00, 6'h20);
      chk1("dec_add_invalid", dec.valid, 1'b0);

      // MULT -2 * 3, latency 4
      issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
      for (int i = 0; i < 4; i++) begin
         chk1("mult_busy", bus.busy_o, 1'b1);
         chk1("mult_nodone", bus.done_o, 1'b0);
         chk32("mult_hi_held", bus.hi_o, 32'h0);
         if (i < 3) tick();
      end
      tick();
      chk1("mult_done", bus.done_o, 1'b1);
      chk1("mult_idle", bus.busy_o, 1'b0);
      chk32("mult_hi", bus.hi_o, 32'hFFFF_FFFF);
      chk32("mult_lo", bus.lo_o, 32'hFFFF_FFFA);
      tick();
      chk1("mult_done_1cyc", bus.done_o, 1'b0);

      issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
      wait_done(n);
      chk32("multu_lat", 32'(n), 32'd4);
      chk32("multu_hi", bus.hi_o, 32'h0000_0002);
      chk32("multu_lo", bus.lo_o, 32'hFFFF_FFFA);

      // Divides
      issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done(n);
      chk32("div_lat", 32'(n), 32'd33);
      chk32("div_lo", bus.lo_o, 32'hFFFF_FFFD);
      chk32("div_hi", bus.hi_o, 32'hFFFF_FFFF);
      tick();

      issue(MD_DIVU, 32'd100, 32'd7);
      wait_done(n);
      chk32("divu_lat", 32'(n), 32'd33);
      chk32("divu_lo", bus.lo_o, 32'd14);
      chk32("divu_hi", bus.hi_o, 32'd2);
      tick();

      issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(n);
      chk32("divmin_lo", bus.lo_o, 32'h8000_0000);
      chk32("divmin_hi", bus.hi_o, 32'h0);
      tick();

      // Divide by zero: immediate, no busy
      issue(MD_DIVU, 32'd5, 32'd0);
      chk1("dz_busy", bus.busy_o, 1'b0);
      chk1("dz_done", bus.done_o, 1'b1);
      chk32("dz_hi", bus.hi_o, 32'h0);
      chk32("dz_lo", bus.lo_o, 32'h0);
      tick();
      chk1("dz_done_1cyc", bus.done_o, 1'b0);

      // DIV 1000 / -3 with MFHI and a held MTHI request during the op
      bus.start_i = 1'b1;
      bus.op_i    = MD_DIV;
      bus.rs_i    = 32'd1000;
      bus.rt_i    = 32'hFFFF_FFFD;
      tick();
      bus.op_i     = MD_MTHI;
      bus.rs_i     = 32'h0000_AAAA;
      bus.mf_req_i = 1'b1;
      #1;
      stall_cnt = 0;
      for (int i = 0; i < 33; i++) begin
         if (bus.stall_o === 1'b1) stall_cnt++;
         tick();
      end
      chk32("mf_stall_cycles", 32'(stall_cnt), 32'd33);
      chk1("mf_done", bus.done_o, 1'b1);
      chk1("mf_stall_released", bus.stall_o, 1'b0);
      chk1("mf_ready", bus.ready_o, 1'b1);
      chk32("mf_div_lo", bus.lo_o, 32'hFFFF_FEB3);
      chk32("mf_div_hi", bus.hi_o, 32'h0000_0001);
      tick();
      bus.start_i  = 1'b0;
      bus.mf_req_i = 1'b0;
      chk32("second_start_hi", bus.hi_o, 32'h0000_AAAA);
      chk32("second_start_lo", bus.lo_o, 32'hFFFF_FEB3);
      chk1("second_start_nodone", bus.done_o, 1'b0);

      // MTHI then MTLO back-to-back
      bus.start_i = 1'b1;
      bus.op_i    = MD_MTHI;
      bus.rs_i    = 32'h0000_1234;
      tick();
      chk32("mthi_hi", bus.hi_o, 32'h0000_1234);
      chk1("mthi_busy", bus.busy_o, 1'b0);
      chk1("mthi_stall", bus.stall_o, 1'b0);
      bus.op_i = MD_MTLO;
      bus.rs_i = 32'h0000_5678;
      tick();
      bus.start_i = 1'b0;
      chk32("mtlo_lo", bus.lo_o, 32'h0000_5678);
      chk32("mtlo_hi", bus.hi_o, 32'h0000_1234);
      chk1("mtlo_nodone", bus.done_o, 1'b0);

      // Flush during DIV after E10
      issue(MD_DIVU, 32'd50, 32'd5);
      repeat (10) tick();
      chk1("flush_pre_busy", bus.busy_o, 1'b1);
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      chk1("flush_idle", bus.busy_o, 1'b0);
      done_seen = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus.done_o === 1'b1) done_seen++;
         tick();
      end
      chk32("flush_no_done", 32'(done_seen), 32'd0);
      chk32("flush_hi", bus.hi_o, 32'h0000_1234);
      chk32("flush_lo", bus.lo_o, 32'h0000_5678);

      // Flush on the MULT writeback edge
      issue(MD_MULT, 32'd5, 32'd6);
      repeat (3) tick();
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      chk1("wbflush_done", bus.done_o, 1'b0);
      chk1("wbflush_idle", bus.busy_o, 1'b0);
      chk32("wbflush_lo", bus.lo_o, 32'h0000_5678);

      // Flush and start together in idle
      bus.flush_i = 1'b1;
      issue(MD_MTHI, 32'h0000_DEAD, 32'd0);
      bus.flush_i = 1'b0;
      chk32("flushstart_hi", bus.hi_o, 32'h0000_1234);

      // Reset in the middle of a MULT
      issue(MD_MULT, 32'd7, 32'd9);
      repeat (2) tick();
      reset_ni = 1'b0;
      #1;
      chk32("midrst_hi", bus.hi_o, 32'h0);
      chk32("midrst_lo", bus.lo_o, 32'h0);
      chk1("midrst_ready", bus.ready_o, 1'b1);
      chk1("midrst_busy", bus.busy_o, 1'b0);
      @(negedge clk);
      reset_ni = 1'b1;
      tick();

      issue(MD_MULT, 32'd7, 32'd9);
      wait_done(n);
      chk32("recover_lat", 32'(n), 32'd4);
      chk32("recover_lo", bus.lo_o, 32'd63);
      chk32("recover_hi", bus.hi_o, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
